full_adder: RTL and testbench

FULL_ADDER -- requirements
Module: full_adder

---
 rtl/full_adder_pkg.sv | 14 +
 rtl/full_adder_bit.sv | 16 +
 rtl/full_adder.sv | 68 ++++++
 tb/tb_full_adder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// Shared constants and types for the ripple-carry full adder.
// Instances specialise the result type to their own WIDTH+1 bits.
package full_adder_pkg;

  localparam int WIDTH_MAX = 64;

  // Widest possible {carry, sum} result.
  typedef logic [WIDTH_MAX:0] sum_carry_max_t;

  function automatic bit width_ok(input int w);
    return (w >= 1) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder cell, chained by full_adder to form the ripple carry.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign sum      = half_sum ^ cin;
  assign cout     = (a & b) | (cin & half_sum);

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with a combinational result and an optional
// registered copy qualified by in_valid.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             out_valid
);

  typedef logic [WIDTH:0] sum_carry_t;

  generate
    if (!width_ok(WIDTH)) begin : g_bad_width
      $error("full_adder: WIDTH out of range 1..%0d", WIDTH_MAX);
    end
  endgenerate

  logic [WIDTH:0] carry;
  sum_carry_t     result;
  sum_carry_t     result_reg;
  logic           valid_reg;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      full_adder_bit u_bit (
        .a    (a[gi]),
        .b    (b[gi]),
        .cin  (carry[gi]),
        .sum  (sum[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  assign cout   = carry[WIDTH];
  assign result = {cout, sum};

  // Inputs are only sampled under in_valid, so unknowns on idle cycles never reach state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg <= '0;
      valid_reg  <= 1'b0;
    end else if (in_valid) begin
      result_reg <= result;
      valid_reg  <= 1'b1;
    end else begin
      valid_reg  <= 1'b0;
    end
  end

  assign sum_q     = result_reg[WIDTH-1:0];
  assign cout_q    = result_reg[WIDTH];
  assign out_valid = valid_reg;

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH 1, 8 and 16 against an
// arithmetic reference (a + b + cin) and a capture/hold model of the register.
module tb_full_adder;

  logic clk;
  logic rst_n;

  logic        a1, b1, c1, v1;
  logic        s1, co1, sq1, coq1, ov1;
  logic [7:0]  a8, b8, s8, sq8;
  logic        c8, v8, co8, coq8, ov8;
  logic [15:0] a16, b16, s16, sq16;
  logic        c16, v16, co16, coq16, ov16;

  int checks   = 0;
  int failures = 0;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(c1), .in_valid(v1),
    .sum(s1), .cout(co1), .sum_q(sq1), .cout_q(coq1), .out_valid(ov1)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(c8), .in_valid(v8),
    .sum(s8), .cout(co8), .sum_q(sq8), .cout_q(coq8), .out_valid(ov8)
  );

  full_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .cin(c16), .in_valid(v16),
    .sum(s16), .cout(co16), .sum_q(sq16), .cout_q(coq16), .out_valid(ov16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected sum/cout for (a,b,cin) = 000,010,001,011,100,110,101,111.
  logic [2:0] vec_abc [8];
  logic [1:0] vec_exp [8];
  initial begin
    vec_abc = '{3'b000, 3'b010, 3'b001, 3'b011, 3'b100, 3'b110, 3'b101, 3'b111};
    vec_exp = '{2'b00,  2'b10,  2'b10,  2'b01,  2'b10,  2'b01,  2'b01,  2'b11};
  end

  initial begin
    logic [16:0] ref16;
    logic [16:0] exp_reg16;
    logic        exp_ov16;

    rst_n = 1'b0;
    {a1, b1, c1, v1} = '0;
    {a8, b8, c8, v8} = '0;
    {a16, b16, c16, v16} = '0;
    #1;
    check("rst_sq1",  64'(sq1),  64'd0);
    check("rst_ov1",  64'(ov1),  64'd0);
    check("rst_sq8",  64'(sq8),  64'd0);
    check("rst_ov16", 64'(ov16), 64'd0);

    // Combinational truth table, held in reset so only the comb path can respond.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] abc;
      logic [1:0] sc;
      abc = vec_abc[i];
      sc  = vec_exp[i];
      a1 = abc[2]; b1 = abc[1]; c1 = abc[0];
      #10;
      $display("tt abc=%b sum=%b cout=%b", abc, s1, co1);
      check("tt_sum",  64'(s1),  64'(sc[1]));
      check("tt_cout", 64'(co1), 64'(sc[0]));
    end
    check("tt_sq_in_reset", 64'(sq1), 64'd0);

    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; #1;
    $display("w8 a=%h b=%h cin=%b sum=%h cout=%b", a8, b8, c8, s8, co8);
    check("w8_wrap_sum",  64'(s8),  64'hFF);
    check("w8_wrap_cout", 64'(co8), 64'd1);
    a8 = 8'h80; b8 = 8'h80; c8 = 1'b0; #1;
    $display("w8 a=%h b=%h cin=%b sum=%h cout=%b", a8, b8, c8, s8, co8);
    check("w8_msb_sum",  64'(s8),  64'h00);
    check("w8_msb_cout", 64'(co8), 64'd1);
    a8 = 8'h00; b8 = 8'h00; c8 = 1'b0; #1;
    $display("w8 a=%h b=%h cin=%b sum=%h cout=%b", a8, b8, c8, s8, co8);
    check("w8_zero_sum",  64'(s8),  64'h00);
    check("w8_zero_cout", 64'(co8), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // Registered path: capture, then hold with out_valid dropping.
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b0; v1 = 1'b1;
    #1;
    check("reg_ov_before_edge", 64'(ov1), 64'd0);
    @(negedge clk);
    $display("reg cap sum_q=%b cout_q=%b out_valid=%b", sq1, coq1, ov1);
    check("reg_cap_sq",  64'(sq1),  64'd0);
    check("reg_cap_coq", 64'(coq1), 64'd1);
    check("reg_cap_ov",  64'(ov1),  64'd1);
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b1; c1 = 1'b0;
    @(negedge clk);
    $display("reg hold sum_q=%b cout_q=%b out_valid=%b", sq1, coq1, ov1);
    check("reg_hold_sq",  64'(sq1),  64'd0);
    check("reg_hold_coq", 64'(coq1), 64'd1);
    check("reg_hold_ov",  64'(ov1),  64'd0);

    // Asynchronous reset between edges discards the captured result.
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; v1 = 1'b1;
    @(negedge clk);
    check("arst_pre_ov", 64'(ov1), 64'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    #1;
    $display("arst sum_q=%b cout_q=%b out_valid=%b sum=%b cout=%b", sq1, coq1, ov1, s1, co1);
    check("arst_sq",   64'(sq1),  64'd0);
    check("arst_coq",  64'(coq1), 64'd0);
    check("arst_ov",   64'(ov1),  64'd0);
    check("arst_sum",  64'(s1),   64'd1);
    check("arst_cout", 64'(co1),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst_rel_ov_pre", 64'(ov1), 64'd0);
    @(negedge clk);
    $display("arst release sum_q=%b cout_q=%b out_valid=%b", sq1, coq1, ov1);
    check("arst_rel_sq", 64'(sq1), 64'd1);
    check("arst_rel_ov", 64'(ov1), 64'd1);
    v1 = 1'b0;

    // Random WIDTH=16 traffic with a capture/hold model of the register.
    exp_reg16 = '0;
    exp_ov16  = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      check("rnd_sq",  64'(sq16),  64'(exp_reg16[15:0]));
      check("rnd_coq", 64'(coq16), 64'(exp_reg16[16]));
      check("rnd_ov",  64'(ov16),  64'(exp_ov16));
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      c16 = 1'($urandom);
      v16 = ($urandom_range(3) != 0);
      if (n % 100 == 0) begin
        a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 1'b1;
      end
      ref16 = 17'(a16) + 17'(b16) + 17'(c16);
      #1;
      $display("rnd %0d a=%h b=%h cin=%b v=%b sum=%h cout=%b", n, a16, b16, c16, v16, s16, co16);
      check("rnd_sum", 64'({co16, s16}), 64'(ref16));
      if (v16) begin
        exp_reg16 = ref16;
        exp_ov16  = 1'b1;
      end else begin
        exp_ov16  = 1'b0;
      end
    end
    @(negedge clk);
    check("rnd_last_sq", 64'({coq16, sq16}), 64'(exp_reg16));
    check("rnd_last_ov", 64'(ov16), 64'(exp_ov16));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
